// File: rtl/sequential_read_axi_lite_slave.sv
// AXI4-Lite target with a preloaded register bank, byte-strobed writes,
// SLVERR on out-of-range words, and read-count / sticky-error sideband status.
module sequential_read_axi_lite_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 16,
  parameter logic [31:0] INIT_BASE          = 32'hA5A5_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [15:0]                     RD_COUNT,
  output logic                            ERR_FLAG
);

  localparam int IDXW  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int BANKW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NBYTE = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [IDXW:0]  NUM_REGS_L = NUM_REGS[IDXW:0];
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate;
  rstate_t r_rstate;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_bank [NUM_REGS];

  logic                          r_awready;
  logic                          r_wready;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [1:0]                    r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [15:0]                   r_rd_count;
  logic                          r_err;

  logic [IDXW-1:0]  w_aw_idx;
  logic [IDXW-1:0]  w_ar_idx;
  logic [BANKW-1:0] w_aw_word;
  logic [BANKW-1:0] w_ar_word;
  logic             w_aw_inrange;
  logic             w_ar_inrange;
  logic             w_wr_hs;
  logic             w_rd_hs;
  logic             w_unused_ok;

  // Byte offset bits are dropped; the bank index is narrowed only after the
  // range check so an out-of-range index can never alias onto a real word.
  assign w_aw_idx     = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ar_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_aw_word    = w_aw_idx[BANKW-1:0];
  assign w_ar_word    = w_ar_idx[BANKW-1:0];
  assign w_aw_inrange = ({1'b0, w_aw_idx} < NUM_REGS_L);
  assign w_ar_inrange = ({1'b0, w_ar_idx} < NUM_REGS_L);

  assign w_wr_hs = r_awready && r_wready && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_rd_hs = r_arready && S_AXI_ARVALID;

  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         w_aw_idx, w_ar_idx};

  // Write channel: the READY pair is offered only once AW and W are both
  // present, so a lone address or data beat is never half-accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= INIT_BASE + 32'(i);
      end
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_wstate  <= W_RESP;
            if (w_aw_inrange) begin
              r_bresp <= RESP_OKAY;
              for (int b = 0; b < NBYTE; b++) begin
                if (S_AXI_WSTRB[b]) begin
                  r_bank[w_aw_word][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
              end
            end else begin
              r_bresp <= RESP_SLVERR;
            end
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end else begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel: the bank word is sampled with a non-blocking read, so a
  // write committing on the same edge is not yet visible in RDATA.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate   <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_rd_count <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rstate  <= R_DATA;
            if (w_ar_inrange) begin
              r_rdata <= r_bank[w_ar_word];
              r_rresp <= RESP_OKAY;
            end else begin
              r_rdata <= '0;
              r_rresp <= RESP_SLVERR;
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_count <= r_rd_count + 16'd1;
            r_rstate   <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Sticky error, set on the same edge that launches either SLVERR response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_err <= 1'b0;
    end else if ((w_wr_hs && !w_aw_inrange) || (w_rd_hs && !w_ar_inrange)) begin
      r_err <= 1'b1;
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign RD_COUNT      = r_rd_count;
  assign ERR_FLAG      = r_err;

endmodule

// File: tb/tb_sequential_read_axi_lite_slave.sv
// Directed bench: a 16-word and an 8-word instance share one stimulus stream
// so in-range and out-of-range behaviour of the same addresses can be compared.
module tb_sequential_read_axi_lite_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        aAwready, aWready, aBvalid, aArready, aRvalid, aErrFlag;
  logic [1:0]  aBresp, aRresp;
  logic [31:0] aRdata;
  logic [15:0] aRdCount;
  logic        bAwready, bWready, bBvalid, bArready, bRvalid, bErrFlag;
  logic [1:0]  bBresp, bRresp;
  logic [31:0] bRdata;
  logic [15:0] bRdCount;

  int          errors = 0;
  int          checks = 0;
  int          rdCount = 0;
  logic [31:0] rdA, rdB;
  logic [1:0]  rsA, rsB, brA, brB;
  longint      t0;

  always #5 ACLK = ~ACLK;

  sequential_read_axi_lite_slave #(.NUM_REGS(16)) dutA (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(aAwready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(aWready), .S_AXI_BRESP(aBresp),
    .S_AXI_BVALID(aBvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(aArready),
    .S_AXI_RDATA(aRdata), .S_AXI_RRESP(aRresp), .S_AXI_RVALID(aRvalid),
    .S_AXI_RREADY(rready), .RD_COUNT(aRdCount), .ERR_FLAG(aErrFlag)
  );

  sequential_read_axi_lite_slave #(.NUM_REGS(8)) dutB (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(bAwready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(bWready), .S_AXI_BRESP(bBresp),
    .S_AXI_BVALID(bBvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(bArready),
    .S_AXI_RDATA(bRdata), .S_AXI_RRESP(bRresp), .S_AXI_RVALID(bRvalid),
    .S_AXI_RREADY(rready), .RD_COUNT(bRdCount), .ERR_FLAG(bErrFlag)
  );

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Holds reset across two falling edges with every master input idle.
  task automatic applyReset();
    ARESET  = 1'b1;
    awaddr  = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready  = 1'b1; rready = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET  = 1'b0;
    rdCount = 0;
  endtask

  // Single read issued on a falling edge; returns after the R beat is taken
  // when RREADY is high.
  task automatic applyStimulus(input logic [5:0] addr);
    bit hs;
    hs      = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (aArready) begin
        hs = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    checkOutput("ar_handshake", 32'(hs), 32'd1);
    @(negedge ACLK);
    arvalid = 1'b0;
    checkOutput("rvalid_latency", 32'(aRvalid), 32'd1);
    rdA = aRdata; rsA = aRresp; rdB = bRdata; rsB = bRresp;
    if (rready) begin
      @(negedge ACLK);
      rdCount++;
    end
  endtask

  task automatic doWrite(input logic [5:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
    bit hs;
    hs      = 1'b0;
    awaddr  = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK);
      if (aAwready && aWready) begin
        hs = 1'b1;
        break;
      end
    end
    checkOutput("aw_w_handshake", 32'(hs), 32'd1);
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("bvalid_after_hs", 32'(aBvalid), 32'd1);
    brA = aBresp; brB = bBresp;
    if (bready) @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset();
    checkOutput("rst_arready", 32'(aArready), 32'd0);
    checkOutput("rst_awready", 32'(aAwready), 32'd0);
    checkOutput("rst_rvalid", 32'(aRvalid), 32'd0);
    checkOutput("rst_bvalid", 32'(aBvalid), 32'd0);
    checkOutput("rst_rdcount", 32'(aRdCount), 32'd0);
    checkOutput("rst_errflag", 32'(aErrFlag), 32'd0);
    checkOutput("rst_rdata", aRdata, 32'd0);
    @(negedge ACLK);
    checkOutput("arready_after_rst", 32'(aArready), 32'd1);

    // Full sweep at one read per two cycles
    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(6'(i * 4));
      checkOutput($sformatf("sweep_rdata_%0d", i), rdA, 32'hA5A5_0000 + 32'(i));
      checkOutput($sformatf("sweep_rresp_%0d", i), 32'(rsA), 32'd0);
      checkOutput($sformatf("sweepB_rdata_%0d", i), rdB,
                  (i < 8) ? 32'hA5A5_0000 + 32'(i) : 32'd0);
      checkOutput($sformatf("sweepB_rresp_%0d", i), 32'(rsB),
                  (i < 8) ? 32'd0 : 32'd2);
    end
    checkOutput("sweep_cycles", 32'(($time - t0) / 10), 32'd32);
    checkOutput("sweep_rdcount", 32'(aRdCount), 32'd16);
    checkOutput("sweep_errflag", 32'(aErrFlag), 32'd0);
    checkOutput("sweepB_errflag", 32'(bErrFlag), 32'd1);
    checkOutput("sweepB_rdcount", 32'(bRdCount), 32'd16);

    // Byte-strobed write
    doWrite(6'h08, 32'h1234_5678, 4'b0101);
    checkOutput("strb_bresp", 32'(brA), 32'd0);
    applyStimulus(6'h08);
    checkOutput("strb_rdata", rdA, 32'hA534_0078);
    checkOutput("strbB_rdata", rdB, 32'hA534_0078);

    // AW presented five cycles before W
    awaddr = 6'h0C; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge ACLK);
      checkOutput($sformatf("aw_only_awready_%0d", j), 32'(aAwready), 32'd0);
      checkOutput($sformatf("aw_only_wready_%0d", j), 32'(aWready), 32'd0);
    end
    wvalid = 1'b1;
    @(negedge ACLK);
    checkOutput("pulse_awready", 32'(aAwready), 32'd1);
    checkOutput("pulse_wready", 32'(aWready), 32'd1);
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("pulse_awready_end", 32'(aAwready), 32'd0);
    checkOutput("pulse_wready_end", 32'(aWready), 32'd0);
    checkOutput("late_w_bvalid", 32'(aBvalid), 32'd1);
    checkOutput("late_w_bresp", 32'(aBresp), 32'd0);
    @(negedge ACLK);
    checkOutput("late_w_bvalid_clr", 32'(aBvalid), 32'd0);
    applyStimulus(6'h0C);
    checkOutput("late_w_rdata", rdA, 32'hDEAD_BEEF);

    // Read and write of the same word handshaking on the same edge
    awaddr = 6'h10; wdata = 32'h1111_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge ACLK);
    checkOutput("hazard_awready", 32'(aAwready), 32'd1);
    araddr = 6'h10; arvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checkOutput("hazard_rvalid", 32'(aRvalid), 32'd1);
    checkOutput("hazard_bvalid", 32'(aBvalid), 32'd1);
    checkOutput("hazard_old_rdata", aRdata, 32'hA5A5_0004);
    @(negedge ACLK);
    rdCount++;
    applyStimulus(6'h10);
    checkOutput("hazard_committed", rdA, 32'h1111_2222);

    // RREADY held low for seven cycles
    rready = 1'b0;
    araddr = 6'h0C; arvalid = 1'b1;
    @(negedge ACLK);
    arvalid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      checkOutput($sformatf("stall_rvalid_%0d", j), 32'(aRvalid), 32'd1);
      checkOutput($sformatf("stall_rdata_%0d", j), aRdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("stall_arready_%0d", j), 32'(aArready), 32'd0);
      checkOutput($sformatf("stall_rdcount_%0d", j), 32'(aRdCount), 32'(rdCount));
      @(negedge ACLK);
    end
    rready = 1'b1;
    @(negedge ACLK);
    rdCount++;
    checkOutput("stall_rvalid_clr", 32'(aRvalid), 32'd0);
    checkOutput("stall_arready_back", 32'(aArready), 32'd1);
    checkOutput("stall_rdcount_inc", 32'(aRdCount), 32'(rdCount));
    checkOutput("stall_rdata_retained", aRdata, 32'hDEAD_BEEF);

    // Reset while both responses are pending
    rready = 1'b0; bready = 1'b0;
    awaddr = 6'h08; wdata = 32'h0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h14; arvalid = 1'b1;
    @(negedge ACLK);
    arvalid = 1'b0;
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("pre_rst_rvalid", 32'(aRvalid), 32'd1);
    checkOutput("pre_rst_bvalid", 32'(aBvalid), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    checkOutput("async_rst_rvalid", 32'(aRvalid), 32'd0);
    checkOutput("async_rst_bvalid", 32'(aBvalid), 32'd0);
    checkOutput("async_rst_rdcount", 32'(aRdCount), 32'd0);
    checkOutput("asyncB_rst_rvalid", 32'(bRvalid), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    rdCount = 0;
    rready = 1'b1; bready = 1'b1;
    checkOutput("post_rst_errflagB", 32'(bErrFlag), 32'd0);
    @(negedge ACLK);
    applyStimulus(6'h08);
    checkOutput("post_rst_init_word", rdA, 32'hA5A5_0002);

    // Out-of-range accesses on the 8-word instance
    doWrite(6'h24, 32'hCAFE_F00D, 4'hF);
    checkOutput("oor_bresp_in", 32'(brA), 32'd0);
    checkOutput("oor_bresp_out", 32'(brB), 32'd2);
    checkOutput("oor_errflagB", 32'(bErrFlag), 32'd1);
    checkOutput("oor_errflagA", 32'(aErrFlag), 32'd0);
    applyStimulus(6'h04);
    checkOutput("oor_no_alias", rdB, 32'hA5A5_0001);
    applyStimulus(6'h20);
    checkOutput("oor_rdataA", rdA, 32'hA5A5_0008);
    checkOutput("oor_rrespA", 32'(rsA), 32'd0);
    checkOutput("oor_rdataB", rdB, 32'd0);
    checkOutput("oor_rrespB", 32'(rsB), 32'd2);
    applyStimulus(6'h24);
    checkOutput("oor_written_A", rdA, 32'hCAFE_F00D);
    checkOutput("oor_rdcountB", 32'(bRdCount), 32'(rdCount));
    checkOutput("oor_rdcountA", 32'(aRdCount), 32'(rdCount));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
